// File: rtl/core_host.sv
// Host controller for the 9-bit core: preload data memory, run one job, drain a result window.
// Latency: start->ld_ready 1 cycle, last load->req 1 cycle, done->RD_ADDR 1 cycle, 2 cycles per result byte.
// Backpressure: ld_valid low stalls LOAD indefinitely; res_ready low holds res_valid/res_data indefinitely.
module core_host #(
    parameter int AW       = 8,
    parameter int LOAD_N   = 64,
    parameter int RES_BASE = 64,
    parameter int RES_N    = 64,
    parameter int TIMEOUT  = 4096,
    parameter int TW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wr_dat,
    input  logic [7:0]    mem_rd_dat,
    output logic          core_reset,
    output logic          req,
    input  logic          done,
    output logic          res_valid,
    output logic [7:0]    res_data,
    input  logic          res_ready,
    output logic          busy,
    output logic          timeout,
    output logic [TW-1:0] cycles,
    output logic [7:0]    checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_RUN,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ld_cnt_q, ld_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [TW-1:0] cycles_q, cycles_d;
    logic [7:0]    checksum_q, checksum_d;
    logic [7:0]    res_data_q, res_data_d;
    logic          timeout_q, timeout_d;
    logic          rd_first_q, rd_first_d;
    logic          ld_xfer;
    logic [TW-1:0] cycles_inc;

    assign ld_xfer    = (state_q == S_LOAD) && ld_valid;
    assign cycles_inc = cycles_q + 1'b1;

    // Memory read data arrives during the first RD_DATA cycle, so it is passed straight
    // through then and taken from the capture register for the rest of a stall.
    assign res_data = rd_first_q ? mem_rd_dat : res_data_q;

    // Output decode: everything is a function of the registered state and counters,
    // except the load write strobe, which follows the live ld_valid handshake.
    assign ld_ready   = (state_q == S_LOAD);
    assign mem_wr_en  = ld_xfer;
    assign mem_wr_dat = ld_xfer ? ld_data : 8'h00;
    assign core_reset = !((state_q == S_REQ) || (state_q == S_RUN));
    assign req        = (state_q == S_REQ);
    assign busy       = (state_q != S_IDLE);
    assign res_valid  = (state_q == S_RD_DATA);
    assign timeout    = timeout_q;
    assign cycles     = cycles_q;
    assign checksum   = checksum_q;

    // Host memory address: load pointer while loading, result pointer while draining.
    always_comb begin
        mem_addr = '0;
        if (state_q == S_LOAD) begin
            mem_addr = ld_cnt_q;
        end else if ((state_q == S_RD_ADDR) || (state_q == S_RD_DATA)) begin
            mem_addr = AW'(RES_BASE) + rd_cnt_q;
        end
    end

    // Job sequencing: next state, counters and status for the load/run/drain phases.
    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        cycles_d   = cycles_q;
        checksum_d = checksum_q;
        res_data_d = res_data_q;
        timeout_d  = timeout_q;
        rd_first_d = (state_q == S_RD_ADDR);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cycles_d   = '0;
                    checksum_d = '0;
                    timeout_d  = 1'b0;
                    ld_cnt_d   = '0;
                    rd_cnt_d   = '0;
                    state_d    = (LOAD_N == 0) ? S_REQ : S_LOAD;
                end
            end
            S_LOAD: begin
                if (ld_xfer) begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == AW'(LOAD_N - 1)) begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // done is deliberately not looked at here
                state_d = S_RUN;
            end
            S_RUN: begin
                // done takes priority over the timeout boundary in the same cycle
                if (done) begin
                    state_d = S_RD_ADDR;
                end else begin
                    cycles_d = cycles_inc;
                    if (cycles_inc == TW'(TIMEOUT)) begin
                        timeout_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (rd_first_q) begin
                    res_data_d = mem_rd_dat;
                end
                if (res_ready) begin
                    checksum_d = checksum_q + res_data;
                    rd_cnt_d   = rd_cnt_q + 1'b1;
                    state_d    = (rd_cnt_q == AW'(RES_N - 1)) ? S_IDLE : S_RD_ADDR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and status registers; reset abandons any job in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ld_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            cycles_q   <= '0;
            checksum_q <= '0;
            res_data_q <= '0;
            timeout_q  <= 1'b0;
            rd_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            cycles_q   <= cycles_d;
            checksum_q <= checksum_d;
            res_data_q <= res_data_d;
            timeout_q  <= timeout_d;
            rd_first_q <= rd_first_d;
        end
    end

endmodule

// File: tb/tb_core_host.sv
// Bench for core_host: directed jobs on a 4-byte-load / 2-byte-result instance and a zero-load timeout instance.
// Latency: checks start, req, exit and drain timing cycle by cycle against expectations.
// Backpressure: exercises gapped ld_valid and 5-cycle res_ready stalls per byte.
module tb_core_host;

    localparam int TO = 12;
    localparam logic [7:0] LD_BYTES [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    localparam logic [7:0] EXP_RES  [2] = '{8'h80, 8'h90};

    logic        clk, reset;
    logic        start, ld_valid, ld_ready, mem_wr_en, core_reset, req, done;
    logic        res_valid, res_ready, busy, timeout;
    logic [7:0]  ld_data, mem_addr, mem_wr_dat, mem_rd_dat, res_data, checksum;
    logic [15:0] cycles;

    logic        z_start, z_ld_ready, z_mem_wr_en, z_core_reset, z_req;
    logic        z_res_valid, z_res_ready, z_busy, z_timeout;
    logic [7:0]  z_mem_addr, z_mem_wr_dat, z_mem_rd_dat, z_res_data, z_checksum;
    logic [15:0] z_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // monitor state: counts of observed transfers and the model checksum of accepted bytes
    int       m_wr, m_res, m_req;
    logic [7:0] m_sum;
    bit       in_job, pv, pr;
    logic [7:0] pd;

    core_host #(.AW(8), .LOAD_N(4), .RES_BASE(64), .RES_N(2), .TIMEOUT(TO), .TW(16)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_dat(mem_wr_dat), .mem_rd_dat(mem_rd_dat),
        .core_reset(core_reset), .req(req), .done(done),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .timeout(timeout), .cycles(cycles), .checksum(checksum)
    );

    core_host #(.AW(8), .LOAD_N(0), .RES_BASE(0), .RES_N(1), .TIMEOUT(8), .TW(16)) u_zero (
        .clk(clk), .reset(reset), .start(z_start),
        .ld_valid(1'b0), .ld_data(8'h00), .ld_ready(z_ld_ready),
        .mem_wr_en(z_mem_wr_en), .mem_addr(z_mem_addr), .mem_wr_dat(z_mem_wr_dat), .mem_rd_dat(z_mem_rd_dat),
        .core_reset(z_core_reset), .req(z_req), .done(1'b0),
        .res_valid(z_res_valid), .res_data(z_res_data), .res_ready(z_res_ready),
        .busy(z_busy), .timeout(z_timeout), .cycles(z_cycles), .checksum(z_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [7:0] a);
        case (a)
            8'd64:   return 8'h80;
            8'd65:   return 8'h90;
            default: return a ^ 8'h3C;
        endcase
    endfunction

    // synchronous-read memory models
    always @(posedge clk) begin
        mem_rd_dat   <= rom(mem_addr);
        z_mem_rd_dat <= z_mem_addr ^ 8'hA5;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction monitor: write stream, req pulses and result stream against the model.
    always @(negedge clk) begin
        if (reset || !busy) begin
            in_job = 1'b0;
            pv     = 1'b0;
        end else begin
            if (!in_job) begin
                in_job = 1'b1;
                m_wr = 0; m_res = 0; m_req = 0; m_sum = 8'h00; pv = 1'b0;
            end
            if (mem_wr_en) begin
                if (m_wr < 4) begin
                    chk("wr_addr", 32'(mem_addr), 32'(m_wr));
                    chk("wr_dat", 32'(mem_wr_dat), 32'(LD_BYTES[m_wr]));
                end else begin
                    chk("wr_extra", 32'(m_wr), 32'd3);
                end
                m_wr++;
            end
            if (req) begin
                m_req++;
                chk("req_core_reset", 32'(core_reset), 32'd0);
            end
            if (res_valid) begin
                if (pv && !pr) chk("res_hold", 32'(res_data), 32'(pd));
                if (res_ready) begin
                    if (m_res < 2) begin
                        chk("res_dat", 32'(res_data), 32'(EXP_RES[m_res]));
                        m_sum = m_sum + EXP_RES[m_res];
                    end else begin
                        chk("res_extra", 32'(m_res), 32'd1);
                    end
                    m_res++;
                end
            end
            pv = res_valid;
            pr = res_ready;
            pd = res_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle and confirm every output takes its reset value without a clock edge.
    task automatic abort_check(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_flags"}, 32'({core_reset, busy, req, res_valid, mem_wr_en, ld_ready, timeout}), 32'b1000000);
        chk({tag, "_vals"}, {cycles, checksum, res_data}, 32'd0);
        chk({tag, "_addr"}, 32'({mem_addr, mem_wr_dat}), 32'd0);
        start = 0; done = 0; ld_valid = 0; res_ready = 0;
        @(posedge clk);
        step();
        reset = 1'b0;
    endtask

    // One job. done_at: RUN cycle index (1-based after req) where done rises; 0 = never.
    // abort: 0 none, 1 reset during RUN, 2 reset during RD_DATA.
    task automatic run_job(input bit stall, input int done_at, input bit done_in_req,
                           input bit mid_start, input int abort);
        int  k, rd_k, hold, nacc, exp_exit, exp_cyc;
        bit  was_rdy, exp_to;
        exp_to   = (done_at == 0) || (done_at > TO);
        exp_cyc  = exp_to ? TO : done_at - 1;
        exp_exit = exp_to ? TO + 1 : done_at + 1;

        start = 1'b1;
        step();
        start = 1'b0;
        chk("ld_ready_lat", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (stall) begin
                ld_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    ld_data = 8'($urandom);
                    step();
                end
            end
            ld_valid = 1'b1;
            ld_data  = LD_BYTES[i];
            k = 0;
            do begin
                was_rdy = ld_ready;
                step();
                k++;
            end while (!was_rdy && k < 50);
            ld_valid = 1'b0;
        end
        chk("req_lat", 32'(req), 32'd1);

        if (done_in_req) done = 1'b1;
        rd_k = 0;
        for (k = 1; k < TO + 40; k++) begin
            step();
            start = 1'b0;
            if (core_reset) begin
                rd_k = k;
                break;
            end
            if (abort == 1 && k == 3) begin
                abort_check("abort_run");
                return;
            end
            done = (done_at != 0) && (k >= done_at);
            if (mid_start && k == 2) start = 1'b1;
        end
        chk("run_exit", 32'(rd_k), 32'(exp_exit));

        hold = 0;
        nacc = 0;
        for (k = 0; k < 200; k++) begin
            if (nacc == 2) begin
                chk("busy_fall", 32'(busy), 32'd0);
                break;
            end
            if (!busy) break;
            if (abort == 2 && res_valid) begin
                abort_check("abort_rd");
                return;
            end
            res_ready = 1'b1;
            if (stall && res_valid && hold < 5) begin
                res_ready = 1'b0;
                hold++;
            end else if (res_valid) begin
                hold = 0;
            end
            if (res_valid && res_ready) nacc++;
            step();
        end
        res_ready = 1'b0;
        done      = 1'b0;
        chk("drain_count", 32'(nacc), 32'd2);

        // status must hold in IDLE
        repeat (2) step();
        chk("cycles", 32'(cycles), 32'(exp_cyc));
        chk("timeout", 32'(timeout), 32'(exp_to));
        chk("checksum", 32'(checksum), 32'(m_sum));
        chk("mon_counts", 32'({8'(m_wr), 8'(m_res), 8'(m_req)}), 32'h00040201);
    endtask

    initial begin
        int  k;
        logic [7:0] got;
        reset = 1'b1;
        start = 0; ld_valid = 0; ld_data = 0; done = 0; res_ready = 0;
        z_start = 0; z_res_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", 32'({core_reset, busy, req, res_valid, mem_wr_en, ld_ready, timeout}), 32'b1000000);
        chk("rst_vals", {cycles, checksum, res_data}, 32'd0);
        chk("rst_addr", 32'({mem_addr, mem_wr_dat}), 32'd0);
        reset = 1'b0;
        step();

        // basic job, with literal pins of the model
        run_job(0, 10, 0, 0, 0);
        chk("basic_cycles_lit", 32'(cycles), 32'd9);
        chk("basic_sum_lit", 32'(checksum), 32'h10);

        run_job(1, 10, 0, 0, 0);   // stalls on both streams
        run_job(0, 0, 0, 0, 0);    // timeout
        chk("timeout_lit", 32'({timeout, cycles}), 32'h1000C);
        run_job(0, 1, 0, 0, 0);    // done in first RUN cycle
        chk("first_run_lit", 32'(cycles), 32'd0);
        run_job(0, 3, 1, 0, 0);    // done high during REQ only, then at RUN cycle 3
        run_job(0, TO, 0, 0, 0);   // done exactly at the timeout boundary
        run_job(0, 5, 0, 1, 0);    // start pulsed mid-job
        run_job(0, 10, 0, 0, 1);   // reset during RUN
        run_job(0, 7, 0, 0, 0);
        run_job(0, 10, 0, 0, 2);   // reset during RD_DATA
        run_job(0, 4, 0, 0, 0);

        // zero-load instance: start->req in one cycle, timeout at 8, one-byte drain
        z_res_ready = 1'b1;
        z_start = 1'b1;
        step();
        z_start = 1'b0;
        chk("z_req_lat", 32'(z_req), 32'd1);
        for (k = 1; k < 40; k++) begin
            step();
            if (z_core_reset) break;
        end
        chk("z_rd_entry", 32'(k), 32'd9);
        got = 8'h00;
        for (k = 0; k < 20; k++) begin
            if (!z_busy) break;
            if (z_res_valid) got = z_res_data;
            step();
        end
        chk("z_res", 32'(got), 32'hA5);
        chk("z_status", 32'({z_timeout, z_cycles}), 32'h10008);
        chk("z_checksum", 32'(z_checksum), 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
